// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data.
// Round-robin on conflict, one-cycle ready pulse per completed access.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [1:0]           grant,
  output logic                 busy
);

  localparam int CW =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_d;
  logic          i_elig;
  logic          d_elig;
  logic          pick_d;
  logic          pick_i;

  // Eligibility masks a request that is being retired this cycle
  always_comb begin
    i_elig = i_req & ~i_ready;
    d_elig = d_req & ~d_ready;
    pick_d = d_elig & (~i_elig | ~last_d);
    pick_i = i_elig & ~pick_d;
  end

  // Access sequencer: grant, hold bus for MEM_LATENCY cycles, retire
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b0;
      i_rdata   <= '0;
      i_ready   <= 1'b0;
      d_rdata   <= '0;
      d_ready   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant     <= 2'b00;
      busy      <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_d) begin
            state     <= BUSY_D;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_read  <= ~d_we;
            mem_write <= d_we;
            grant     <= 2'b10;
            busy      <= 1'b1;
            cnt       <= '0;
            last_d    <= 1'b1;
          end else if (pick_i) begin
            state     <= BUSY_I;
            mem_addr  <= i_addr;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            grant     <= 2'b01;
            busy      <= 1'b1;
            cnt       <= '0;
            last_d    <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (cnt == CNT_LAST) begin
            if (state == BUSY_I) begin
              i_rdata <= mem_rdata;
              i_ready <= 1'b1;
            end else begin
              if (mem_read) begin
                d_rdata <= mem_rdata;
              end
              d_ready <= 1'b1;
            end
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            grant     <= 2'b00;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vector bench for mem_port_arbiter.
// Includes a small memory model and a sustained-request sequence.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ready;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  grant;
  logic        busy;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(
    .WORD_SIZE   (16),
    .MEM_LATENCY (4)
  ) dut (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .grant     (grant),
    .busy      (busy)
  );

  // Memory model: writes land on any edge with mem_write high
  logic [15:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge Clk) begin
    if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
  end

  typedef struct {
    logic        rst_n;
    logic        ir;
    logic        dr;
    logic        dwe;
    logic [15:0] da;
    logic [15:0] dwd;
    logic [1:0]  g;
    logic        bz;
    logic        rd;
    logic        wr;
    logic [15:0] ma;
    logic        iry;
    logic        dry;
    logic [15:0] ird;
    logic [15:0] drd;
    logic [15:0] mwd;
  } vec_t;

  vec_t tbl[$];
  vec_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic st(input logic rst, input logic ir,
                    input logic dr, input logic we,
                    input logic [15:0] da,
                    input logic [15:0] wd);
    cur.rst_n = rst;
    cur.ir    = ir;
    cur.dr    = dr;
    cur.dwe   = we;
    cur.da    = da;
    cur.dwd   = wd;
  endtask

  task automatic ex(input int n, input logic [1:0] g,
                    input logic bz, input logic rd,
                    input logic wr, input logic [15:0] ma,
                    input logic iry, input logic dry,
                    input logic [15:0] ird,
                    input logic [15:0] drd,
                    input logic [15:0] mwd);
    for (int k = 0; k < n; k++) begin
      cur.g   = g;
      cur.bz  = bz;
      cur.rd  = rd;
      cur.wr  = wr;
      cur.ma  = ma;
      cur.iry = iry;
      cur.dry = dry;
      cur.ird = ird;
      cur.drd = drd;
      cur.mwd = mwd;
      tbl.push_back(cur);
    end
  endtask

  logic [54:0] act;
  logic [54:0] exp_v;
  logic [1:0]  gs [4];
  int          gc [4];
  int          ng;
  logic        pb;

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 16'h0000;
    mem[16'h0010] = 16'h6000;
    mem[16'h0020] = 16'h1234;

    // reset with both requests up
    st(0, 1, 1, 0, 16'h0020, 16'h0000);
    ex(2, 2'b00, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    // conflict right after reset: data first
    st(1, 1, 1, 0, 16'h0020, 16'h0000);
    ex(1, 2'b00, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    ex(4, 2'b10, 1, 1, 0, 16'h0020, 0, 0, 16'h0000, 16'h0000, 0);
    ex(1, 2'b00, 0, 0, 0, 16'h0020, 0, 1, 16'h0000, 16'h1234, 0);
    st(1, 1, 0, 0, 16'h0020, 16'h0000);
    ex(4, 2'b01, 1, 1, 0, 16'h0010, 0, 0, 16'h0000, 16'h1234, 0);
    ex(1, 2'b00, 0, 0, 0, 16'h0010, 1, 0, 16'h6000, 16'h1234, 0);
    // request dropped: retired fetch must not be re-granted
    st(1, 0, 0, 0, 16'h0020, 16'h0000);
    ex(2, 2'b00, 0, 0, 0, 16'h0010, 0, 0, 16'h6000, 16'h1234, 0);
    // data write
    st(1, 0, 1, 1, 16'h0100, 16'hBEEF);
    ex(1, 2'b00, 0, 0, 0, 16'h0010, 0, 0, 16'h6000, 16'h1234, 0);
    ex(4, 2'b10, 1, 0, 1, 16'h0100, 0, 0, 16'h6000, 16'h1234,
       16'hBEEF);
    ex(1, 2'b00, 0, 0, 0, 16'h0100, 0, 1, 16'h6000, 16'h1234, 0);
    // read back the written word
    st(1, 0, 1, 0, 16'h0100, 16'h0000);
    ex(1, 2'b00, 0, 0, 0, 16'h0100, 0, 0, 16'h6000, 16'h1234, 0);
    ex(4, 2'b10, 1, 1, 0, 16'h0100, 0, 0, 16'h6000, 16'h1234, 0);
    ex(1, 2'b00, 0, 0, 0, 16'h0100, 0, 1, 16'h6000, 16'hBEEF, 0);
    // conflict with last grant = data: fetch wins, then data
    st(1, 1, 1, 0, 16'h0020, 16'h0000);
    ex(1, 2'b00, 0, 0, 0, 16'h0100, 0, 0, 16'h6000, 16'hBEEF, 0);
    ex(4, 2'b01, 1, 1, 0, 16'h0010, 0, 0, 16'h6000, 16'hBEEF, 0);
    ex(1, 2'b00, 0, 0, 0, 16'h0010, 1, 0, 16'h6000, 16'hBEEF, 0);
    ex(3, 2'b10, 1, 1, 0, 16'h0020, 0, 0, 16'h6000, 16'hBEEF, 0);
    st(1, 0, 1, 0, 16'h0020, 16'h0000);
    ex(1, 2'b10, 1, 1, 0, 16'h0020, 0, 0, 16'h6000, 16'hBEEF, 0);
    ex(1, 2'b00, 0, 0, 0, 16'h0020, 0, 1, 16'h6000, 16'h1234, 0);
    st(1, 0, 0, 0, 16'h0020, 16'h0000);
    ex(1, 2'b00, 0, 0, 0, 16'h0020, 0, 0, 16'h6000, 16'h1234, 0);
    // reset abort at cnt=2 of a fetch
    st(1, 1, 0, 0, 16'h0020, 16'h0000);
    ex(1, 2'b00, 0, 0, 0, 16'h0020, 0, 0, 16'h6000, 16'h1234, 0);
    ex(2, 2'b01, 1, 1, 0, 16'h0010, 0, 0, 16'h6000, 16'h1234, 0);
    st(0, 1, 0, 0, 16'h0020, 16'h0000);
    ex(1, 2'b01, 1, 1, 0, 16'h0010, 0, 0, 16'h6000, 16'h1234, 0);
    st(1, 0, 0, 0, 16'h0020, 16'h0000);
    ex(4, 2'b00, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    // fresh fetch after reset
    st(1, 1, 0, 0, 16'h0020, 16'h0000);
    ex(1, 2'b00, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
    ex(4, 2'b01, 1, 1, 0, 16'h0010, 0, 0, 16'h0000, 16'h0000, 0);
    ex(1, 2'b00, 0, 0, 0, 16'h0010, 1, 0, 16'h6000, 16'h0000, 0);
    st(1, 0, 0, 0, 16'h0020, 16'h0000);
    ex(1, 2'b00, 0, 0, 0, 16'h0010, 0, 0, 16'h6000, 16'h0000, 0);

    Reset_N = 1'b0;
    i_req   = 1'b1;
    i_addr  = 16'h0010;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 16'h0020;
    d_wdata = 16'h0000;
    @(posedge Clk);
    #1;

    for (int v = 0; v < tbl.size(); v++) begin
      Reset_N = tbl[v].rst_n;
      i_req   = tbl[v].ir;
      d_req   = tbl[v].dr;
      d_we    = tbl[v].dwe;
      d_addr  = tbl[v].da;
      d_wdata = tbl[v].dwd;
      act = {grant, busy, mem_read, mem_write, mem_addr,
             i_ready, d_ready, i_rdata, d_rdata};
      exp_v = {tbl[v].g, tbl[v].bz, tbl[v].rd, tbl[v].wr,
               tbl[v].ma, tbl[v].iry, tbl[v].dry,
               tbl[v].ird, tbl[v].drd};
      n_cmp++;
      if (act !== exp_v) begin
        n_bad++;
        $display("FAIL vec%0d outputs: got %h want %h",
                 v, act, exp_v);
      end
      if (tbl[v].wr) begin
        n_cmp++;
        if (mem_wdata !== tbl[v].mwd) begin
          n_bad++;
          $display("FAIL vec%0d mem_wdata: got %h want %h",
                   v, mem_wdata, tbl[v].mwd);
        end
      end
      @(posedge Clk);
      #1;
    end

    // sustained dual requests: D,I,D,I every 5 cycles
    i_req  = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 16'h0020;
    ng = 0;
    pb = busy;
    for (int c = 1; c <= 40 && ng < 4; c++) begin
      @(posedge Clk);
      #1;
      if (busy && !pb) begin
        gs[ng] = grant;
        gc[ng] = c;
        ng++;
      end
      pb = busy;
    end
    n_cmp++;
    if (ng != 4) begin
      n_bad++;
      $display("FAIL sustained_timeout: got %0d grants want 4",
               ng);
    end
    for (int k = 0; k < ng; k++) begin
      n_cmp++;
      if (gs[k] !== ((k % 2 == 0) ? 2'b10 : 2'b01) ||
          gc[k] != 1 + 5 * k) begin
        n_bad++;
        $display("FAIL sustained_grant%0d: got %b@%0d want %b@%0d",
                 k, gs[k], gc[k],
                 (k % 2 == 0) ? 2'b10 : 2'b01, 1 + 5 * k);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported, fixed-latency memory between the pipelined CPU's instruction-fetch port and data-access port. Each access is latched, held on the memory bus for `MEM_LATENCY` cycles, and completed with a one-cycle ready pulse and captured read data. The block sits between the CPU's `readM1/address1/data1` and `readM2/writeM2/address2/data2` ports and the shared memory model. Fetch stalls are derived from the ready pulses.

## Interface
- `WORD_SIZE`, 16, address/data width.
- `MEM_LATENCY`, 4, cycles one access occupies the memory bus; legal range ≥1.

Ports:
- `Clk` in 1: clock, rising edge.
- `Reset_N` in 1: synchronous, active-low reset.
- `i_req` in 1: fetch request, level, held until `i_ready`.
- `i_addr` in WORD_SIZE: fetch address.
- `i_rdata` out WORD_SIZE: fetched word, valid when `i_ready`=1, held afterwards.
- `i_ready` out 1: one-cycle completion pulse, fetch.
- `d_req` in 1: data request, level, held until `d_ready`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in WORD_SIZE: data address.
- `d_wdata` in WORD_SIZE: write data.
- `d_rdata` out WORD_SIZE: read word, valid when `d_ready`=1; unchanged by writes.
- `d_ready` out 1: one-cycle completion pulse, data.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_addr` out WORD_SIZE: memory address.
- `mem_wdata` out WORD_SIZE: memory write data.
- `mem_rdata` in WORD_SIZE: memory read data; valid in the last busy cycle.
- `grant` out 2: 2'b01 fetch, 2'b10 data, 2'b00 idle.
- `busy` out 1: access in progress.

## Operation
- States: IDLE, BUSY_I, BUSY_D. Counter `cnt`, width max(1, clog2(MEM_LATENCY)).
- **Eligibility in IDLE:** a requester is eligible if `req`=1 and its own `ready` is 0 in that cycle. Masking by `ready` prevents re-granting a request that is being retired.
- **Arbitration in IDLE:**
  - Only one requester eligible: that requester wins.
  - Both eligible: data wins, unless `last_grant`=D, in which case fetch wins. This is round-robin on conflict.
  - `last_grant` updates on each grant.
- **On grant (clock edge):**
  - Latch addr, we and wdata into `mem_addr` and `mem_wdata`.
  - Set `mem_read` = !we and `mem_write` = we. Fetch is always a read.
  - Set `cnt`=0, `grant` and `busy`.
- **BUSY_x:**
  - Outputs hold stable; requester input changes and `req` drops are ignored.
  - `cnt` increments each cycle.
  - At the edge where `cnt`=MEM_LATENCY-1:
    - Capture `mem_rdata` into `i_rdata` or `d_rdata` (read only).
    - Pulse the matching `ready` for the next cycle.
    - Clear `mem_read`, `mem_write`, `grant`, `busy`; return to IDLE.
- **Writes:** commit to memory at the end of the final busy cycle. `d_rdata` is unchanged.
- **Reset values:** state IDLE, `cnt` 0, `last_grant`=I, all outputs 0 (including `rdata` registers and `mem_addr`).

## Timing
- Request seen in cycle 0 (IDLE) → `mem_*` asserted in cycles 1..L (L=MEM_LATENCY) → `ready` high in cycle L+1.
- The next grant can be taken at the end of cycle L+1, so back-to-back accesses have a period of L+1 cycles.
- L=1: strobes high for one cycle; `ready` in cycle 2.
- **Reset mid-access:** at the next edge all strobes drop, state returns to IDLE, and no `ready` pulse is issued for the aborted access.
- **Simultaneous events:**
  - A `req` arriving during BUSY waits until IDLE.
  - A `ready` pulse and a new grant to the other requester occur in the same cycle L+1.

## Test plan
- **Reset:** hold `Reset_N`=0 for 2 cycles with `i_req`=`d_req`=1 → all outputs 0, `grant`=00, no strobes.
- **Single fetch**, L=4, `i_addr`=0x0010, memory returns 0x6000 → `mem_read`=1 with `mem_addr`=0x0010 in cycles 1–4; `i_ready`=1 and `i_rdata`=0x6000 in cycle 5 only.
- **Conflict after reset**, both requests in cycle 0 → data served first (`grant`=10 in cycles 1–4, `d_ready` in cycle 5); fetch `grant`=01 in cycles 6–9, `i_ready` in cycle 10.
- **Data write**, `d_we`=1, `d_addr`=0x0100, `d_wdata`=0xBEEF → `mem_write`=1, `mem_wdata`=0xBEEF, `mem_read`=0 in cycles 1–4; `d_ready` in cycle 5; `d_rdata` unchanged.
- **Sustained dual requests** (re-asserted after each `ready`) → grant order D, I, D, I with no fetch starvation; exact period L+1.
- **Reset abort:** reset asserted while `cnt`=2 of a fetch → strobes 0 on the next cycle; `i_ready` never pulses; a fresh `i_req` after reset completes normally in L+1 cycles.
